stride_agu: RTL

- Multi-channel 2D strided address generator on the same single-cycle register bus as the existing one-shot stride calculator.
- Each channel holds a base address, row stride, column stride and a ROWS x COLS extent.
- Each read of a channel's NEXT register returns the current address and advances a row-major iterator.
- Addresses are produced incrementally (adders only, no multipliers), with optional auto-wrap at the end of the extent.

---
 rtl/stride_agu.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/stride_agu.sv
// Multi-channel 2D strided address generator behind a single-cycle register bus.
// Each NEXT read returns the current address and steps a row-major iterator using adders only.
module stride_agu #(
  parameter int                      DataWidth    = 32,
  parameter int                      AddressWidth = 32,
  parameter int                      NumChannels  = 2,
  parameter logic [AddressWidth-1:0] BaseAddr     = 32'h0004_0000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    agu_req_i,
  input  logic [AddressWidth-1:0] agu_addr_i,
  input  logic                    agu_we_i,
  input  logic [DataWidth/8-1:0]  agu_be_i,
  input  logic [DataWidth-1:0]    agu_wdata_i,
  output logic                    agu_rvalid_o,
  output logic [DataWidth-1:0]    agu_rdata_o,
  output logic                    agu_err_o
);

  if (DataWidth != 32) begin : g_dw_check
    $error("stride_agu: DataWidth must be 32");
  end
  if (NumChannels < 1 || NumChannels > 8) begin : g_nch_check
    $error("stride_agu: NumChannels must be 1..8");
  end

  localparam logic [AddressWidth:0] WinSize = (AddressWidth+1)'(NumChannels * 32);

  function automatic logic [DataWidth-1:0] merge_be(input logic [DataWidth-1:0] old_v,
                                                    input logic [DataWidth-1:0] new_v,
                                                    input logic [DataWidth/8-1:0] be);
    logic [DataWidth-1:0] res;
    res = old_v;
    for (int q = 0; q < DataWidth/8; q++) begin
      res[8*q +: 8] = be[q] ? new_v[8*q +: 8] : old_v[8*q +: 8];
    end
    return res;
  endfunction

  logic [DataWidth-1:0] base_r       [NumChannels];
  logic [DataWidth-1:0] row_stride_r [NumChannels];
  logic [DataWidth-1:0] col_stride_r [NumChannels];
  logic [DataWidth-1:0] dims_r       [NumChannels];
  logic [DataWidth-1:0] cur_r        [NumChannels];
  logic [DataWidth-1:0] row_r        [NumChannels];
  logic [15:0]          i_r          [NumChannels];
  logic [15:0]          j_r          [NumChannels];
  logic                 en_r         [NumChannels];
  logic                 wrap_r       [NumChannels];
  logic                 done_r       [NumChannels];

  logic [15:0]          cols_m1_s    [NumChannels];
  logic [15:0]          rows_m1_s    [NumChannels];
  logic [DataWidth-1:0] reg_val_s    [NumChannels];

  logic [AddressWidth:0] offset_s;
  logic                  in_range_s;
  logic [2:0]            ch_s;
  logic [2:0]            reg_s;
  logic                  err_s;
  logic                  wr_s;
  logic                  rd_s;
  logic [DataWidth-1:0]  rd_mux_s;

  // Address decode and access classification.
  always_comb begin
    offset_s   = {1'b0, agu_addr_i} - {1'b0, BaseAddr};
    in_range_s = (offset_s < WinSize);
    ch_s       = offset_s[7:5];
    reg_s      = offset_s[4:2];
    err_s      = agu_req_i && (!in_range_s || (agu_addr_i[1:0] != 2'b00) ||
                               (agu_we_i && (reg_s >= 3'd5)));
    wr_s       = agu_req_i && agu_we_i && !err_s;
    rd_s       = agu_req_i && !agu_we_i && !err_s;
  end

  // Per-channel extent limits (zero-sized dims behave as 1) and register read values.
  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      cols_m1_s[c] = (dims_r[c][15:0] == 16'd0)  ? 16'd0 : dims_r[c][15:0] - 16'd1;
      rows_m1_s[c] = (dims_r[c][31:16] == 16'd0) ? 16'd0 : dims_r[c][31:16] - 16'd1;
      case (reg_s)
        3'd0:    reg_val_s[c] = base_r[c];
        3'd1:    reg_val_s[c] = row_stride_r[c];
        3'd2:    reg_val_s[c] = col_stride_r[c];
        3'd3:    reg_val_s[c] = dims_r[c];
        3'd4:    reg_val_s[c] = {29'd0, wrap_r[c], 1'b0, en_r[c]};
        3'd5:    reg_val_s[c] = {i_r[c], j_r[c]};
        3'd6:    reg_val_s[c] = {30'd0, en_r[c] & ~done_r[c], done_r[c]};
        default: reg_val_s[c] = cur_r[c];
      endcase
    end
  end

  // Select the addressed channel's read value.
  always_comb begin
    rd_mux_s = '0;
    for (int c = 0; c < NumChannels; c++) begin
      rd_mux_s = rd_mux_s | ((ch_s == 3'(c)) ? reg_val_s[c] : '0);
    end
  end

  // Registered bus response; a reset drops any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      agu_rvalid_o <= 1'b0;
      agu_rdata_o  <= '0;
      agu_err_o    <= 1'b0;
    end else begin
      agu_rvalid_o <= agu_req_i;
      agu_err_o    <= err_s;
      agu_rdata_o  <= rd_s ? rd_mux_s : '0;
    end
  end

  // Configuration writes, RESTART and iterator advance on NEXT reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChannels; c++) begin
        base_r[c]       <= '0;
        row_stride_r[c] <= '0;
        col_stride_r[c] <= '0;
        dims_r[c]       <= '0;
        cur_r[c]        <= '0;
        row_r[c]        <= '0;
        i_r[c]          <= 16'd0;
        j_r[c]          <= 16'd0;
        en_r[c]         <= 1'b0;
        wrap_r[c]       <= 1'b0;
        done_r[c]       <= 1'b0;
      end
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        if (wr_s && (ch_s == 3'(c))) begin
          case (reg_s)
            3'd0: base_r[c]       <= merge_be(base_r[c], agu_wdata_i, agu_be_i);
            3'd1: row_stride_r[c] <= merge_be(row_stride_r[c], agu_wdata_i, agu_be_i);
            3'd2: col_stride_r[c] <= merge_be(col_stride_r[c], agu_wdata_i, agu_be_i);
            3'd3: dims_r[c]       <= merge_be(dims_r[c], agu_wdata_i, agu_be_i);
            3'd4: begin
              if (agu_be_i[0]) begin
                en_r[c]   <= agu_wdata_i[0];
                wrap_r[c] <= agu_wdata_i[2];
                if (agu_wdata_i[1]) begin
                  i_r[c]    <= 16'd0;
                  j_r[c]    <= 16'd0;
                  cur_r[c]  <= base_r[c];
                  row_r[c]  <= base_r[c];
                  done_r[c] <= 1'b0;
                end
              end
            end
            default: ;
          endcase
        end else if (rd_s && (ch_s == 3'(c)) && (reg_s == 3'd7) && en_r[c] && !done_r[c]) begin
          if (j_r[c] < cols_m1_s[c]) begin
            j_r[c]   <= j_r[c] + 16'd1;
            cur_r[c] <= cur_r[c] + col_stride_r[c];
          end else if (i_r[c] < rows_m1_s[c]) begin
            j_r[c]   <= 16'd0;
            i_r[c]   <= i_r[c] + 16'd1;
            row_r[c] <= row_r[c] + row_stride_r[c];
            cur_r[c] <= row_r[c] + row_stride_r[c];
          end else if (wrap_r[c]) begin
            i_r[c]   <= 16'd0;
            j_r[c]   <= 16'd0;
            cur_r[c] <= base_r[c];
            row_r[c] <= base_r[c];
          end else begin
            done_r[c] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
